// File: rtl/bram_stream_loader.sv
// bram_stream_loader: packs a byte stream little-endian into WIDTH-bit words and
// issues one bram_wrapper write per word to consecutive word addresses. It waits
// for the wrapper's finished pulse before collecting the next word.
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of accepted bytes);
// when undefined, checksum_out is tied to 0.
module bram_stream_loader #(
    parameter int ADDRS = 1024,
    parameter int WIDTH = 2048,
    localparam int ADDR_SIZE = $clog2(ADDRS)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [ADDR_SIZE-1:0] base_addr_in,
    input  logic [ADDR_SIZE:0]   num_words_in,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid_in,
    output logic                 byte_ready_out,
    output logic [ADDR_SIZE-1:0] wr_addr_out,
    output logic [WIDTH-1:0]     wr_data_out,
    output logic                 wr_enable_out,
    input  logic                 wr_finished_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [7:0]           checksum_out
);
    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_SIZE:0] ONE_WORD = {{ADDR_SIZE{1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StWait, StDone} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE:0]   words_q, words_d;
    logic                 ready_q, ready_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    // Next-state logic; output flags are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    addr_d  = base_addr_in;
                    words_d = num_words_in;
                    cnt_d   = '0;
                    data_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (num_words_in == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (byte_valid_in && ready_q) begin
                    data_d[8*cnt_q +: 8] = byte_in;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrite: state_d = StWait;
            StWait: begin
                if (wr_finished_in) begin
                    words_d = words_q - 1'b1;
                    if (words_q == ONE_WORD) begin
                        state_d = StDone;
                    end else begin
                        // Address wraps naturally at the ADDR_SIZE boundary.
                        addr_d  = addr_q + 1'b1;
                        state_d = StCollect;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StCollect);
        en_d    = (state_d == StWrite);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    // State and registered outputs; async reset abandons any load in progress.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign byte_ready_out = ready_q;
    assign wr_addr_out    = addr_q;
    assign wr_data_out    = data_q;
    assign wr_enable_out  = en_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum_out   = csum_q;
`else
    assign checksum_out   = 8'h00;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader (ADDRS=16, WIDTH=32) with the wrapper
// modelled as an 8-cycle writer. Expected writes and checksum come from the byte
// list of each load. Honours LOADER_CHECKSUM_EN for the expected checksum.
`timescale 1ns/1ps
module tb_bram_stream_loader;
    localparam int ADDRS  = 16;
    localparam int WIDTH  = 32;
    localparam int AW     = 4;
    localparam int NW     = AW + 1;
    localparam int BYTES  = WIDTH / 8;
    localparam int WR_LAT = 8;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             start_in;
    logic [AW-1:0]    base_addr_in;
    logic [NW-1:0]    num_words_in;
    logic [7:0]       byte_in;
    logic             byte_valid_in;
    logic             byte_ready_out;
    logic [AW-1:0]    wr_addr_out;
    logic [WIDTH-1:0] wr_data_out;
    logic             wr_enable_out;
    logic             wr_finished_in;
    logic             busy_out;
    logic             done_out;
    logic [7:0]       checksum_out;

    always #5 clk_in = ~clk_in;

    bram_stream_loader #(
        .ADDRS(ADDRS),
        .WIDTH(WIDTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .base_addr_in   (base_addr_in),
        .num_words_in   (num_words_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .wr_enable_out  (wr_enable_out),
        .wr_finished_in (wr_finished_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .checksum_out   (checksum_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]       src[$];
    logic [AW-1:0]    got_addr[$];
    logic [WIDTH-1:0] got_data[$];
    int               wcnt;
    int               ready_in_wait;
    int               rdy_cycles;
    int               busy_low;
    bit               done_seen;
    bit               done_after_fin;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int nbytes);
        src.delete();
        for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
    endtask

    // Advance one clock, sample outputs 1ns later, and run the wrapper model.
    task automatic tick();
        bit fin_at_edge;
        fin_at_edge = wr_finished_in;
        @(posedge clk_in);
        #1;
        wr_finished_in = 1'b0;
        if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) wr_finished_in = 1'b1;
        end
        if (wr_enable_out) begin
            got_addr.push_back(wr_addr_out);
            got_data.push_back(wr_data_out);
            wcnt = WR_LAT;
        end
        if (byte_ready_out && (wr_enable_out || wcnt > 0 || wr_finished_in)) ready_in_wait++;
        if (byte_ready_out && got_addr.size() == 0) rdy_cycles++;
        if (done_out && !done_seen) begin
            done_seen      = 1'b1;
            done_after_fin = fin_at_edge;
        end
        if (!busy_out && !done_seen) busy_low++;
    endtask

    // mode: 0 back-to-back, 1 valid toggling (starting low), 2 random valid.
    task automatic run_load(input int base, input int n, input int mode, input bit glitch,
                            input string nm);
        logic [WIDTH-1:0] exp_data;
        logic [7:0]       exp_csum;
        int               idx;
        int               total;
        int               budget;
        bit               v;
        bit               acc;
        total = n * BYTES;
        got_addr.delete();
        got_data.delete();
        ready_in_wait  = 0;
        rdy_cycles     = 0;
        busy_low       = 0;
        done_seen      = 1'b0;
        done_after_fin = 1'b0;

        start_in     = 1'b1;
        base_addr_in = AW'(base);
        num_words_in = NW'(n);
        tick();
        start_in = 1'b0;
        check_val({nm, " busy at t+1"}, 64'(busy_out), 64'd1);

        if (n == 0) begin
            check_val({nm, " done at t+1"}, 64'(done_out), 64'd1);
            tick();
            check_val({nm, " busy at t+2"}, 64'(busy_out), 64'd0);
            check_val({nm, " done at t+2"}, 64'(done_out), 64'd0);
            check_val({nm, " write count"}, 64'(got_addr.size()), 64'd0);
            return;
        end

        idx    = 0;
        budget = n * (BYTES * 16 + WR_LAT + 8) + 10;
        for (int i = 0; i < budget && !done_seen; i++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (i % 2) == 1;
                default: v = ($urandom % 3) != 0;
            endcase
            byte_valid_in = (idx < total) && v;
            byte_in       = (idx < total) ? src[idx] : 8'($urandom);
            if (glitch) begin
                start_in     = (i == 2);
                base_addr_in = AW'(9);
                num_words_in = NW'(5);
            end
            acc = byte_valid_in && byte_ready_out;
            tick();
            if (acc) idx++;
        end
        start_in      = 1'b0;
        byte_valid_in = 1'b0;

        check_val({nm, " done seen"}, 64'(done_seen), 64'd1);
        check_val({nm, " done after fin"}, 64'(done_after_fin), 64'd1);
        check_val({nm, " write count"}, 64'(got_addr.size()), 64'(n));
        for (int w = 0; w < n; w++) begin
            exp_data = '0;
            for (int k = 0; k < BYTES; k++) exp_data = exp_data | (WIDTH'(src[w*BYTES+k]) << (8*k));
            if (w < got_addr.size()) begin
                check_val($sformatf("%s addr[%0d]", nm, w), 64'(got_addr[w]),
                          64'((base + w) % ADDRS));
                check_val($sformatf("%s data[%0d]", nm, w), 64'(got_data[w]), 64'(exp_data));
            end
        end
        exp_csum = 8'h00;
`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < total; i++) exp_csum = exp_csum ^ src[i];
`endif
        check_val({nm, " checksum"}, 64'(checksum_out), 64'(exp_csum));
        check_val({nm, " bytes taken"}, 64'(idx), 64'(total));
        check_val({nm, " ready in wait"}, 64'(ready_in_wait), 64'd0);
        check_val({nm, " busy dropped"}, 64'(busy_low), 64'd0);
        if (mode == 0) check_val({nm, " collect cycles"}, 64'(rdy_cycles), 64'(BYTES));
        if (mode == 1) check_val({nm, " collect cycles"}, 64'(rdy_cycles), 64'(2 * BYTES));
        tick();
        check_val({nm, " done one cycle"}, 64'(done_out), 64'd0);
        check_val({nm, " idle after done"}, 64'(busy_out), 64'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check_val({nm, " addr"}, 64'(wr_addr_out), 64'd0);
        check_val({nm, " data"}, 64'(wr_data_out), 64'd0);
        check_val({nm, " checksum"}, 64'(checksum_out), 64'd0);
        check_val({nm, " ctrl"}, 64'({wr_enable_out, byte_ready_out, busy_out, done_out}), 64'd0);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        start_in       = 1'b0;
        base_addr_in   = '0;
        num_words_in   = '0;
        byte_in        = '0;
        byte_valid_in  = 1'b0;
        wr_finished_in = 1'b0;
        wcnt           = 0;
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_n_in = 1'b1;
        tick();
        check_all_zero("after reset");

        // Single word with known bytes.
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(3, 1, 0, 1'b0, "single");
        if (got_data.size() > 0) check_val("single literal data", 64'(got_data[0]), 64'h44332211);
`ifdef LOADER_CHECKSUM_EN
        check_val("single literal checksum", 64'(checksum_out), 64'h44);
`endif

        // Multi-word load wrapping 15 -> 0.
        fill_random(3 * BYTES);
        run_load(14, 3, 0, 1'b0, "wrap");

        // Bursty source, same bytes as the single-word load.
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(3, 1, 1, 1'b0, "bursty");

        // Zero-length load.
        run_load(7, 0, 0, 1'b0, "zero");

        // Start pulsed mid-collect must be ignored.
        fill_random(2 * BYTES);
        run_load(1, 2, 0, 1'b1, "start busy");

        // Reset during WAIT.
        fill_random(2 * BYTES);
        start_in     = 1'b1;
        base_addr_in = AW'(2);
        num_words_in = NW'(2);
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 40 && wcnt == 0; i++) begin
            byte_valid_in = 1'b1;
            byte_in       = src[i % BYTES];
            tick();
        end
        byte_valid_in = 1'b0;
        check_val("midreset reached wait", 64'(wcnt > 0), 64'd1);
        rst_n_in = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk_in);
        #1;
        rst_n_in       = 1'b1;
        wcnt           = 0;
        wr_finished_in = 1'b0;
        tick();
        check_val("midreset idle", 64'({busy_out, wr_enable_out}), 64'd0);
        fill_random(BYTES);
        run_load(5, 1, 0, 1'b0, "post reset");

        // Randomized loads.
        for (int r = 0; r < 6; r++) begin
            int n;
            int base;
            n    = $urandom_range(1, 4);
            base = $urandom_range(0, ADDRS - 1);
            fill_random(n * BYTES);
            run_load(base, n, 2, 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
